// File: rtl/conv_pkg.sv
// Shared definitions for the window generator and the convolution stage:
// window-offset helper, packed-window width helper and a default window word type.
package conv_pkg;

  // Default geometry shared with the convolution stage.
  localparam int unsigned CONV_N        = 3;
  localparam int unsigned CONV_BIT_SIZE = 32;

  // Shift-line index of window element (r,c) once the completing pixel is at index 0.
  function automatic int unsigned win_offset(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned n,
                                             input int unsigned w);
    return (n - 1 - r) * w + (n - 1 - c);
  endfunction

  // Bit width of one packed n x n window of bit_size pixels.
  function automatic int unsigned win_bits(input int unsigned n,
                                           input int unsigned bit_size);
    return n * n * bit_size;
  endfunction

  // Packed window word at the default geometry.
  typedef logic [CONV_N*CONV_N*CONV_BIT_SIZE-1:0] conv_win_t;

endpackage

// File: rtl/pixel_shift_line.sv
// Pixel shift line: Depth-entry delay line with every entry exposed as a tap.
// Ports:
//   clk, res_n : clock, asynchronous active-low reset (clears all entries)
//   shift_en   : shift din into entry 0, oldest entry drops out
//   din        : incoming pixel
//   taps       : entry i at [i*BitSize +: BitSize], entry 0 is the newest
module pixel_shift_line #(
  parameter int unsigned Depth   = 11,
  parameter int unsigned BitSize = 32
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  logic                       shift_en,
  input  logic [BitSize-1:0]         din,
  output logic [Depth*BitSize-1:0]   taps
);

  // Shift register; newest pixel lands in the low slice.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      taps <= '0;
    end else if (shift_en) begin
      taps <= {taps[(Depth-1)*BitSize-1:0], din};
    end
  end

endmodule

// File: rtl/window_gen_stage.sv
// Window generator: turns a raster pixel stream into packed N x N windows
// for every valid stride-1 position of a square InWidth x InWidth frame.
// Ports:
//   clk, res_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : pixel handshake (in_ready is combinational from out_ready)
//   in_pixel              : raster-order pixel, top-left first
//   out_valid/out_ready   : window handshake, single registered output entry
//   out_data              : element k = r*N+c at [k*BitSize +: BitSize], r=0 top row
//   out_last              : final window of the frame (only with WINDOW_GEN_LAST_EN)
// Build option: define WINDOW_GEN_LAST_EN to add the out_last port.
module window_gen_stage
  import conv_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned BitSize    = 32,
  parameter int unsigned ImageWidth = 4
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BitSize-1:0]         in_pixel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(N*N)*BitSize-1:0]   out_data
`ifdef WINDOW_GEN_LAST_EN
  ,
  output logic                       out_last
`endif
);

  localparam int unsigned InWidth = ImageWidth + N - 1;
  localparam int unsigned Depth   = (N - 1) * InWidth + N;
  localparam int unsigned WinW    = win_bits(N, BitSize);
  localparam int unsigned CntW    = (InWidth > 1) ? $clog2(InWidth) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(InWidth - 1);
  localparam logic [CntW-1:0] FirstWin = CntW'(N - 1);

  logic [CntW-1:0]          col;
  logic [CntW-1:0]          row;
  logic [Depth*BitSize-1:0] taps;
  logic [Depth*BitSize-1:0] post_c;
  logic [BitSize-1:0]       unused_tap_top;
  logic [WinW-1:0]          win_c;
  logic                     accept_c;
  logic                     win_hit_c;

  assign in_ready  = !out_valid || out_ready;
  assign accept_c  = in_valid && in_ready;
  assign win_hit_c = accept_c && (row >= FirstWin) && (col >= FirstWin);

  pixel_shift_line #(
    .Depth   (Depth),
    .BitSize (BitSize)
  ) u_shift_line (
    .clk      (clk),
    .res_n    (res_n),
    .shift_en (accept_c),
    .din      (in_pixel),
    .taps     (taps)
  );

  // Shift-line contents as they will be after this accept, so the window
  // can be loaded in the same cycle as its completing pixel.
  assign post_c         = {taps[(Depth-1)*BitSize-1:0], in_pixel};
  assign unused_tap_top = taps[Depth*BitSize-1 -: BitSize];

  // Gather the N x N window from the post-shift line.
  always_comb begin
    win_c = '0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        win_c[(r*N+c)*BitSize +: BitSize] =
          post_c[win_offset(r, c, N, InWidth)*BitSize +: BitSize];
      end
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      col <= '0;
      row <= '0;
    end else if (accept_c) begin
      if (col == LastIdx) begin
        col <= '0;
        row <= (row == LastIdx) ? '0 : row + CntW'(1);
      end else begin
        col <= col + CntW'(1);
      end
    end
  end

  // Single-entry output register; a load wins over a drain in the same cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (win_hit_c) begin
      out_valid <= 1'b1;
      out_data  <= win_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef WINDOW_GEN_LAST_EN
  // Marks the window completed by the bottom-right pixel of the frame.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_last <= 1'b0;
    end else if (win_hit_c) begin
      out_last <= (row == LastIdx) && (col == LastIdx);
    end
  end
`endif

endmodule
